vga_frame_monitor: RTL
======================

# vga_frame_monitor

Receive-side counterpart to the SoC's VGA output path. It samples the 640x480 RGB444 pixel stream and the HS/VS syncs on the pixel clock and recovers line and frame timing from the sync edges. It reduces every frame to a checksum, a lit-pixel count and optionally a CRC, and flags timing violations. It sits on the VGA pins inside the SoC for on-chip self-test and drives the frame-level checks in the testbench.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line
- H_SYNC, 96, HS pulse width
- H_BP, 48, HS back porch
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, VS pulse width in lines
- V_BP, 33, VS back porch in lines
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- vga_clk_i  in  1  pixel clock; the only clock
- vga_rst_i  in  1  reset, asynchronous, active-low
- vga_r_i / vga_g_i / vga_b_i  in  4 each  pixel colour
- vga_hs_i  in  1  horizontal sync
- vga_vs_i  in  1  vertical sync
- clr_i  in  1  clears the sticky error flags
- locked_o  out  1  timing lock
- frame_done_o  out  1  one-cycle pulse when new results are valid
- frame_sum_o  out  32  sum of {r,g,b} over active pixels, modulo 2^32
- frame_lit_o  out  20  count of active pixels with a nonzero colour
- frame_crc_o  out  16  CRC-16 of the active pixels
- frame_num_o  out  16  count of completed clean frames, wraps
- err_hlen_o  out  1  sticky flag: line-length error
- err_vlen_o  out  1  sticky flag: frame-length error

## Operation
- Reset: all outputs 0, state UNLOCKED, counters 0.
- All inputs get one register stage. Edges are detected on the registered syncs. The sync start is the transition to the SYNC_POL level.
- hcnt (11 b) is set to 0 on the cycle the registered HS first shows SYNC_POL, increments otherwise and saturates at 2047. vcnt (10 b) is set to 0 on the VS start and increments on each HS start.
- A pixel is active when hcnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). Pixel (0,0) is the first active pixel.
- On every active pixel: sum += {r,g,b} as a 12-bit value; lit += (value != 0). With the CRC feature compiled in, the CRC is also updated.
- HS start with hcnt+1 != H_TOTAL is an h-error, except on the first HS after leaving UNLOCKED. VS start with vcnt+1 != V_TOTAL is a v-error.
- States:
  - UNLOCKED: wait for a VS start, then clear the accumulators and go to MEASURE.
  - MEASURE: on the next VS start, if the frame was clean, publish results, assert locked_o and go to LOCKED. Otherwise go back to UNLOCKED and re-arm.
  - LOCKED: on each VS start, publish results. Any h-error or v-error clears locked_o, sets the matching sticky flag and goes to UNLOCKED.
- A frame is published only if it was clean. Publishing updates sum, lit, crc and num (num+1), pulses frame_done_o, then clears the accumulators.
- Sticky errors stay set until clr_i. If clr_i and a new error happen in the same cycle, the error wins.
- Simultaneous HS and VS start: the line check runs first, then the frame check, in the same cycle.

## Timing
- The syncs' transition to SYNC_POL is first sampled at clock edge k. The edge is detected in cycle k+1. State, frame_done_o, the results and the flags update at edge k+2.
- Pixel data is delayed by the same amount as the syncs, so pixel alignment is exact.
- Results hold between pulses.
- Asserting reset mid-frame discards the partial frame. The first frame_done_o after reset comes at the second VS start after reset.

## Configuration
- VGA_FRAME_MONITOR_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over the 12-bit pixels, MSB first, 12 bits per clock. frame_crc_o is published with the other results.
- Undefined: no CRC logic is built and frame_crc_o is tied to 0.

## Structure
- Package vga_frame_monitor_pkg holds:
  - the state enum (UNLOCKED, MEASURE, LOCKED)
  - the CRC polynomial and init constants
  - the default 640x480 timing localparams
- One sub-module, vga_frame_acc: the sum, lit and CRC accumulators, with clear and enable inputs.

## Test plan
- Reset, then three nominal frames of constant 0xFFF → frame_done_o at the second and third VS starts; frame_sum_o = 0x4AFB5000, frame_lit_o = 0x4B000, frame_num_o = 1 then 2, locked_o = 1.
- Locked; a frame that is all black except pixel (0,0) = 0x555 → sum = 0x555, lit = 1.
- Locked; one line 799 clocks long → err_hlen_o = 1 and locked_o = 0 at edge k+2; no frame_done_o for that frame; clr_i clears the flag. Relock takes two VS starts.
- Locked; a frame of 524 lines → err_vlen_o = 1, locked_o = 0, frame_num_o unchanged.
- Reset asserted at line 200 mid-frame → all outputs 0 immediately; the next published frame_num_o is 1.
- With VGA_FRAME_MONITOR_CRC_EN: a frame with all pixels 0 → frame_crc_o matches the bench's reference CRC-16 model. Without the macro: frame_crc_o = 0.

Source files
------------

// File: rtl/vga_frame_monitor_pkg.sv
// Shared types and constants for the VGA frame monitor.
package vga_frame_monitor_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    MEASURE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Default 640x480 @ 60 Hz timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // CRC-16-CCITT advanced by one 12-bit pixel, MSB first.
  function automatic logic [15:0] crc16_px(input logic [15:0] crc_in, input logic [11:0] px);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ px[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_acc.sv
// Per-frame accumulators: pixel sum, lit-pixel count and optional CRC.
// Optional CRC controlled by macro VGA_FRAME_MONITOR_CRC_EN.
module vga_frame_acc
  import vga_frame_monitor_pkg::*;
(
  input  logic        vga_clk_i,
  input  logic        vga_rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [11:0] pix_i,
  output logic [31:0] sum_o,
  output logic [19:0] lit_o,
  output logic [15:0] crc_o
);

  logic [31:0] sum_q, sum_d;
  logic [19:0] lit_q, lit_d;

  // Clear wins over accumulate; otherwise add each active pixel.
  always_comb begin
    sum_d = sum_q;
    lit_d = lit_q;
    if (clr_i) begin
      sum_d = '0;
      lit_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + {20'd0, pix_i};
      lit_d = lit_q + {19'd0, (pix_i != 12'd0)};
    end
  end

  // Sum and lit registers.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      sum_q <= '0;
      lit_q <= '0;
    end else begin
      sum_q <= sum_d;
      lit_q <= lit_d;
    end
  end

  assign sum_o = sum_q;
  assign lit_o = lit_q;

`ifdef VGA_FRAME_MONITOR_CRC_EN
  logic [15:0] crc_q, crc_d;

  // CRC restarts from its init value on clear.
  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = CRC_INIT;
    else if (en_i) crc_d = crc16_px(crc_q, pix_i);
  end

  // CRC register.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) crc_q <= CRC_INIT;
    else            crc_q <= crc_d;
  end

  assign crc_o = crc_q;
`else
  // No CRC hardware: report a constant zero.
  assign crc_o = 16'd0;
`endif

endmodule

// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: recovers timing from HS/VS edges, reduces
// each clean frame to sum/lit/CRC and flags line/frame length errors.
// Optional CRC controlled by macro VGA_FRAME_MONITOR_CRC_EN.
module vga_frame_monitor
  import vga_frame_monitor_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_TOTAL  = DEF_H_TOTAL,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_TOTAL  = DEF_V_TOTAL,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk_i,
  input  logic        vga_rst_i,
  input  logic [3:0]  vga_r_i,
  input  logic [3:0]  vga_g_i,
  input  logic [3:0]  vga_b_i,
  input  logic        vga_hs_i,
  input  logic        vga_vs_i,
  input  logic        clr_i,
  output logic        locked_o,
  output logic        frame_done_o,
  output logic [31:0] frame_sum_o,
  output logic [19:0] frame_lit_o,
  output logic [15:0] frame_crc_o,
  output logic [15:0] frame_num_o,
  output logic        err_hlen_o,
  output logic        err_vlen_o
);

  localparam logic [10:0] H_LO  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_TOT = 12'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);

  logic        hs_q, hs_d, vs_q, vs_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic        hs_start_q, hs_start_d, vs_start_q, vs_start_d, clr_q, clr_d;
  logic [11:0] pix0_q, pix0_d, pix1_q, pix1_d, pix2_q, pix2_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  state_e      state_q, state_d;
  logic        locked_q, locked_d, done_q, done_d, dirty_q, dirty_d, skip_h_q, skip_h_d;
  logic        err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d;
  logic [31:0] frame_sum_q, frame_sum_d;
  logic [19:0] frame_lit_q, frame_lit_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic        pix_active, h_err, v_err, acc_clr, publish;
  logic [31:0] acc_sum;
  logic [19:0] acc_lit;
  logic [15:0] acc_crc;

  // Input capture, sync edge detection and the matching pixel delay line.
  always_comb begin
    hs_d       = vga_hs_i;
    vs_d       = vga_vs_i;
    clr_d      = clr_i;
    hs_prev_d  = hs_q;
    vs_prev_d  = vs_q;
    hs_start_d = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    vs_start_d = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
    pix0_d     = {vga_r_i, vga_g_i, vga_b_i};
    pix1_d     = pix0_q;
    pix2_d     = pix1_q;
  end

  // Line counter saturates; frame counter restarts on VS and steps per line.
  always_comb begin
    hcnt_d = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
    if (hs_start_q) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (vs_start_q)      vcnt_d = '0;
    else if (hs_start_q) vcnt_d = vcnt_q + 10'd1;
  end

  assign pix_active = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
                      (vcnt_q >= V_LO) && (vcnt_q < V_HI);
  assign h_err = hs_start_q && !skip_h_q && (({1'b0, hcnt_q} + 12'd1) != H_TOT);
  assign v_err = vs_start_q && (({1'b0, vcnt_q} + 11'd1) != V_TOT);

  // Lock FSM, sticky error flags and result publishing.
  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    done_d      = 1'b0;
    dirty_d     = dirty_q;
    skip_h_d    = skip_h_q;
    err_hlen_d  = err_hlen_q & ~clr_q;
    err_vlen_d  = err_vlen_q & ~clr_q;
    acc_clr     = 1'b0;
    publish     = 1'b0;
    frame_sum_d = frame_sum_q;
    frame_lit_d = frame_lit_q;
    frame_num_d = frame_num_q;
    if (hs_start_q) skip_h_d = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        locked_d = 1'b0;
        if (vs_start_q) begin
          acc_clr  = 1'b1;
          dirty_d  = 1'b0;
          skip_h_d = 1'b1;  // the line in progress was not measured from its start
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (h_err) dirty_d = 1'b1;
        if (vs_start_q) begin
          if (!dirty_q && !h_err && !v_err) begin
            publish  = 1'b1;
            locked_d = 1'b1;
            state_d  = LOCKED;
          end else begin
            state_d = UNLOCKED;
          end
        end
      end
      LOCKED: begin
        if (h_err || v_err) begin
          locked_d   = 1'b0;
          state_d    = UNLOCKED;
          err_hlen_d = err_hlen_d | h_err;
          err_vlen_d = err_vlen_d | v_err;
        end else if (vs_start_q) begin
          publish = 1'b1;
        end
      end
      default: begin
        locked_d = 1'b0;
        state_d  = UNLOCKED;
      end
    endcase
    if (publish) begin
      done_d      = 1'b1;
      acc_clr     = 1'b1;
      frame_sum_d = acc_sum;
      frame_lit_d = acc_lit;
      frame_num_d = frame_num_q + 16'd1;
    end
  end

  // All state registers.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      hs_prev_q   <= ~SYNC_POL;
      vs_prev_q   <= ~SYNC_POL;
      hs_start_q  <= 1'b0;
      vs_start_q  <= 1'b0;
      clr_q       <= 1'b0;
      pix0_q      <= '0;
      pix1_q      <= '0;
      pix2_q      <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      state_q     <= UNLOCKED;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      dirty_q     <= 1'b0;
      skip_h_q    <= 1'b0;
      err_hlen_q  <= 1'b0;
      err_vlen_q  <= 1'b0;
      frame_sum_q <= '0;
      frame_lit_q <= '0;
      frame_num_q <= '0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      hs_start_q  <= hs_start_d;
      vs_start_q  <= vs_start_d;
      clr_q       <= clr_d;
      pix0_q      <= pix0_d;
      pix1_q      <= pix1_d;
      pix2_q      <= pix2_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      state_q     <= state_d;
      locked_q    <= locked_d;
      done_q      <= done_d;
      dirty_q     <= dirty_d;
      skip_h_q    <= skip_h_d;
      err_hlen_q  <= err_hlen_d;
      err_vlen_q  <= err_vlen_d;
      frame_sum_q <= frame_sum_d;
      frame_lit_q <= frame_lit_d;
      frame_num_q <= frame_num_d;
    end
  end

  vga_frame_acc u_acc (
    .vga_clk_i (vga_clk_i),
    .vga_rst_i (vga_rst_i),
    .clr_i     (acc_clr),
    .en_i      (pix_active),
    .pix_i     (pix2_q),
    .sum_o     (acc_sum),
    .lit_o     (acc_lit),
    .crc_o     (acc_crc)
  );

`ifdef VGA_FRAME_MONITOR_CRC_EN
  logic [15:0] frame_crc_q, frame_crc_d;

  // Published CRC follows the other results.
  always_comb begin
    frame_crc_d = publish ? acc_crc : frame_crc_q;
  end

  // Published CRC register.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) frame_crc_q <= '0;
    else            frame_crc_q <= frame_crc_d;
  end

  assign frame_crc_o = frame_crc_q;
`else
  // The accumulator reports a constant zero CRC in this build.
  assign frame_crc_o = acc_crc;
`endif

  assign locked_o     = locked_q;
  assign frame_done_o = done_q;
  assign frame_sum_o  = frame_sum_q;
  assign frame_lit_o  = frame_lit_q;
  assign frame_num_o  = frame_num_q;
  assign err_hlen_o   = err_hlen_q;
  assign err_vlen_o   = err_vlen_q;

endmodule
